// File: rtl/m3_pkg.sv
// Shared types and default configuration for the m3 ramp sequencer.
// Optional power ramp is enabled by defining M3_POWER_RAMP_EN.
package m3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_INC,
        DIR_DEC
    } dir_e;

    localparam int DEF_PERIOD_W    = 22;
    localparam int DEF_PERIOD_MAX  = 4000000;
    localparam int DEF_PERIOD_MIN  = 40;
    localparam int DEF_STEPS       = 12;
    localparam int DEF_RAMP_SHIFT  = 4;
    localparam int DEF_HOLD_ROUNDS = 3;
    localparam int DEF_POWER_W     = 10;
    localparam int DEF_POWER_MIN   = 0;
    localparam int DEF_POWER_MAX   = 1000;
    localparam int DEF_POWER_INIT  = 100;
    localparam int DEF_POWER_STEP  = 10;

endpackage

// File: rtl/m3_ramp_sequencer_if.sv
// Control/status bundle between a controller (master) and the ramp sequencer (slave).
interface m3_ramp_sequencer_if import m3_pkg::*; #(
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int POWER_W  = DEF_POWER_W
) ();

    logic                startI;
    logic                forceStopI;
    logic                invRotateI;
    logic                speedIncI;
    logic                speedDecI;
    logic                powerIncI;
    logic                powerDecI;
    logic [3:0]          stepO;
    logic                stepStbO;
    logic                roundStbO;
    logic [PERIOD_W-1:0] periodO;
    logic [POWER_W-1:0]  powerO;
    logic                runO;
    logic                haltO;

    modport master (
        output startI, forceStopI, invRotateI, speedIncI, speedDecI, powerIncI, powerDecI,
        input  stepO, stepStbO, roundStbO, periodO, powerO, runO, haltO
    );

    modport slave (
        input  startI, forceStopI, invRotateI, speedIncI, speedDecI, powerIncI, powerDecI,
        output stepO, stepStbO, roundStbO, periodO, powerO, runO, haltO
    );

endinterface

// File: rtl/m3_period_ramp.sv
// Combinational step-period ramp: shortens or lengthens by period>>RAMP_SHIFT, then clamps.
module m3_period_ramp import m3_pkg::*; #(
    parameter int PERIOD_W   = DEF_PERIOD_W,
    parameter int PERIOD_MIN = DEF_PERIOD_MIN,
    parameter int PERIOD_MAX = DEF_PERIOD_MAX,
    parameter int RAMP_SHIFT = DEF_RAMP_SHIFT
) (
    input  logic [PERIOD_W-1:0] period_i,
    input  dir_e                dir_i,
    output logic [PERIOD_W-1:0] period_o
);

    localparam logic [PERIOD_W:0] MIN_X = (PERIOD_W+1)'(PERIOD_MIN);
    localparam logic [PERIOD_W:0] MAX_X = (PERIOD_W+1)'(PERIOD_MAX);

    logic [PERIOD_W:0] delta;
    logic [PERIOD_W:0] wide;

    // One extra bit keeps the lengthening sum from wrapping before the clamp.
    always_comb begin
        delta    = {1'b0, period_i >> RAMP_SHIFT};
        wide     = {1'b0, period_i};
        period_o = period_i;
        case (dir_i)
            DIR_INC: wide = {1'b0, period_i} - delta;
            DIR_DEC: wide = {1'b0, period_i} + delta;
            default: wide = {1'b0, period_i};
        endcase
        if (wide < MIN_X) begin
            period_o = MIN_X[PERIOD_W-1:0];
        end else if (wide > MAX_X) begin
            period_o = MAX_X[PERIOD_W-1:0];
        end else begin
            period_o = wide[PERIOD_W-1:0];
        end
    end

endmodule

// File: rtl/m3_ramp_sequencer.sv
// Step/round sequencer with hold-qualified period ramping for a stepper drive.
// Define M3_POWER_RAMP_EN to let powerIncI/powerDecI adjust the power level each round.
module m3_ramp_sequencer import m3_pkg::*; #(
    parameter int PERIOD_W    = DEF_PERIOD_W,
    parameter int PERIOD_MAX  = DEF_PERIOD_MAX,
    parameter int PERIOD_MIN  = DEF_PERIOD_MIN,
    parameter int STEPS       = DEF_STEPS,
    parameter int RAMP_SHIFT  = DEF_RAMP_SHIFT,
    parameter int HOLD_ROUNDS = DEF_HOLD_ROUNDS,
    parameter int POWER_W     = DEF_POWER_W,
    parameter int POWER_MIN   = DEF_POWER_MIN,
    parameter int POWER_MAX   = DEF_POWER_MAX,
    parameter int POWER_INIT  = DEF_POWER_INIT,
    parameter int POWER_STEP  = DEF_POWER_STEP
) (
    input logic clkI,
    input logic nRstI,
    m3_ramp_sequencer_if.slave bus
);

    localparam int                  HOLD_W       = (HOLD_ROUNDS > 0) ? $clog2(HOLD_ROUNDS + 1) : 1;
    localparam logic [HOLD_W-1:0]   HOLD_N       = HOLD_W'(HOLD_ROUNDS);
    localparam logic [PERIOD_W-1:0] PERIOD_MAX_N = PERIOD_W'(PERIOD_MAX);
    localparam logic [3:0]          LAST_STEP    = 4'(STEPS - 1);
    localparam logic [POWER_W-1:0]  POWER_INIT_N = POWER_W'(POWER_INIT);

    state_e              state_q, state_d;
    logic [3:0]          step_q, step_d, next_step;
    logic                step_stb_q, step_stb_d;
    logic                round_stb_q, round_stb_d;
    logic [PERIOD_W-1:0] remain_q, remain_d;
    logic [PERIOD_W-1:0] period_q, period_d, ramped_period;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    dir_e                last_dir_q, last_dir_d, speed_req;
    logic                wrap;

`ifdef M3_POWER_RAMP_EN
    localparam logic [POWER_W-1:0] POWER_MIN_N  = POWER_W'(POWER_MIN);
    localparam logic [POWER_W-1:0] POWER_MAX_N  = POWER_W'(POWER_MAX);
    localparam logic [POWER_W-1:0] POWER_STEP_N = POWER_W'(POWER_STEP);
    localparam logic [POWER_W:0]   PWR_STEP_X   = (POWER_W+1)'(POWER_STEP);
    localparam logic [POWER_W:0]   PWR_MAX_X    = (POWER_W+1)'(POWER_MAX);
    localparam logic [POWER_W:0]   PWR_FLOOR_X  = (POWER_W+1)'(POWER_MIN + POWER_STEP);
    logic [POWER_W-1:0] power_q, power_d;
`else
    logic [POWER_W:0] unused_power;
    assign unused_power = {bus.powerIncI ^ bus.powerDecI, POWER_W'(POWER_MIN + POWER_MAX + POWER_STEP)};
`endif

    assign speed_req = (bus.speedIncI && !bus.speedDecI) ? DIR_INC :
                       (bus.speedDecI && !bus.speedIncI) ? DIR_DEC : DIR_NONE;

    m3_period_ramp #(
        .PERIOD_W  (PERIOD_W),
        .PERIOD_MIN(PERIOD_MIN),
        .PERIOD_MAX(PERIOD_MAX),
        .RAMP_SHIFT(RAMP_SHIFT)
    ) u_ramp (
        .period_i(period_q),
        .dir_i   (speed_req),
        .period_o(ramped_period)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        step_stb_d  = 1'b0;
        round_stb_d = 1'b0;
        remain_d    = remain_q;
        period_d    = period_q;
        hold_d      = hold_q;
        last_dir_d  = last_dir_q;
`ifdef M3_POWER_RAMP_EN
        power_d     = power_q;
`endif
        if (bus.invRotateI) begin
            wrap      = (step_q == 4'd0);
            next_step = wrap ? LAST_STEP : step_q - 4'd1;
        end else begin
            wrap      = (step_q == LAST_STEP);
            next_step = wrap ? 4'd0 : step_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.startI) state_d = ST_ARM;
            end
            ST_ARM: begin
                remain_d = period_q;
                step_d   = 4'd0;
                state_d  = bus.forceStopI ? ST_HALT : ST_RUN;
            end
            ST_RUN: begin
                if (bus.forceStopI) begin
                    state_d = ST_HALT;
                end else if (remain_q > PERIOD_W'(1)) begin
                    remain_d = remain_q - PERIOD_W'(1);
                end else begin
                    // Reload uses the old period; a ramped period only applies from the next step.
                    remain_d   = period_q;
                    step_stb_d = 1'b1;
                    step_d     = next_step;
                    if (wrap) begin
                        round_stb_d = 1'b1;
                        if (speed_req == DIR_NONE) begin
                            hold_d = HOLD_N;
                        end else if (speed_req != last_dir_q) begin
                            hold_d     = HOLD_N;
                            last_dir_d = speed_req;
                        end else if (hold_q != '0) begin
                            hold_d = hold_q - HOLD_W'(1);
                        end else begin
                            period_d = ramped_period;
                            hold_d   = HOLD_N;
                        end
`ifdef M3_POWER_RAMP_EN
                        if (bus.powerIncI && !bus.powerDecI) begin
                            power_d = ({1'b0, power_q} + PWR_STEP_X >= PWR_MAX_X) ? POWER_MAX_N
                                                                                 : power_q + POWER_STEP_N;
                        end else if (bus.powerDecI && !bus.powerIncI) begin
                            power_d = ({1'b0, power_q} < PWR_FLOOR_X) ? POWER_MIN_N
                                                                      : power_q - POWER_STEP_N;
                        end
`endif
                    end
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        // Dropping startI is the only way back to IDLE, so IDLE entry values are applied here.
        if (!bus.startI) begin
            state_d     = ST_IDLE;
            step_d      = 4'd0;
            step_stb_d  = 1'b0;
            round_stb_d = 1'b0;
            period_d    = PERIOD_MAX_N;
            hold_d      = HOLD_N;
`ifdef M3_POWER_RAMP_EN
            power_d     = POWER_INIT_N;
`endif
        end
    end

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state_q     <= ST_IDLE;
            step_q      <= 4'd0;
            step_stb_q  <= 1'b0;
            round_stb_q <= 1'b0;
            remain_q    <= PERIOD_MAX_N;
            period_q    <= PERIOD_MAX_N;
            hold_q      <= HOLD_N;
            last_dir_q  <= DIR_INC;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            step_stb_q  <= step_stb_d;
            round_stb_q <= round_stb_d;
            remain_q    <= remain_d;
            period_q    <= period_d;
            hold_q      <= hold_d;
            last_dir_q  <= last_dir_d;
        end
    end

`ifdef M3_POWER_RAMP_EN
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            power_q <= POWER_INIT_N;
        end else begin
            power_q <= power_d;
        end
    end
    assign bus.powerO = power_q;
`else
    assign bus.powerO = POWER_INIT_N;
`endif

    assign bus.stepO     = step_q;
    assign bus.stepStbO  = step_stb_q;
    assign bus.roundStbO = round_stb_q;
    assign bus.periodO   = period_q;
    assign bus.runO      = (state_q == ST_RUN);
    assign bus.haltO     = (state_q == ST_HALT);

endmodule

// File: tb/tb_m3_ramp_sequencer.sv
// Directed bench for m3_ramp_sequencer; three instances cover stepping, hold-qualified ramping and settling.
// Power expectations follow M3_POWER_RAMP_EN when it is defined.
module tb_m3_ramp_sequencer;

    logic clk;
    logic n_rst;
    int   check_count = 0;
    int   fail_count  = 0;

    m3_ramp_sequencer_if if_a ();
    m3_ramp_sequencer_if if_b ();
    m3_ramp_sequencer_if if_c ();

    m3_ramp_sequencer #(.PERIOD_MAX(400)) dut_a (
        .clkI(clk), .nRstI(n_rst), .bus(if_a)
    );
    m3_ramp_sequencer #(.PERIOD_MAX(400), .STEPS(2)) dut_b (
        .clkI(clk), .nRstI(n_rst), .bus(if_b)
    );
    m3_ramp_sequencer #(.PERIOD_MAX(400), .STEPS(2), .HOLD_ROUNDS(0), .POWER_INIT(105)) dut_c (
        .clkI(clk), .nRstI(n_rst), .bus(if_c)
    );

    logic        step_stb  [3];
    logic        round_stb [3];
    logic [3:0]  step      [3];
    logic [21:0] period    [3];
    logic [9:0]  power     [3];
    logic        run       [3];
    logic        halt      [3];

    assign step_stb[0] = if_a.stepStbO;  assign step_stb[1] = if_b.stepStbO;  assign step_stb[2] = if_c.stepStbO;
    assign round_stb[0] = if_a.roundStbO; assign round_stb[1] = if_b.roundStbO; assign round_stb[2] = if_c.roundStbO;
    assign step[0] = if_a.stepO;         assign step[1] = if_b.stepO;         assign step[2] = if_c.stepO;
    assign period[0] = if_a.periodO;     assign period[1] = if_b.periodO;     assign period[2] = if_c.periodO;
    assign power[0] = if_a.powerO;       assign power[1] = if_b.powerO;       assign power[2] = if_c.powerO;
    assign run[0] = if_a.runO;           assign run[1] = if_b.runO;           assign run[2] = if_c.runO;
    assign halt[0] = if_a.haltO;         assign halt[1] = if_b.haltO;         assign halt[2] = if_c.haltO;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int d, input logic start, input logic force_stop, input logic inv_rotate,
                                 input logic speed_inc, input logic speed_dec,
                                 input logic power_inc, input logic power_dec);
        case (d)
            0: begin
                if_a.startI = start; if_a.forceStopI = force_stop; if_a.invRotateI = inv_rotate;
                if_a.speedIncI = speed_inc; if_a.speedDecI = speed_dec;
                if_a.powerIncI = power_inc; if_a.powerDecI = power_dec;
            end
            1: begin
                if_b.startI = start; if_b.forceStopI = force_stop; if_b.invRotateI = inv_rotate;
                if_b.speedIncI = speed_inc; if_b.speedDecI = speed_dec;
                if_b.powerIncI = power_inc; if_b.powerDecI = power_dec;
            end
            default: begin
                if_c.startI = start; if_c.forceStopI = force_stop; if_c.invRotateI = inv_rotate;
                if_c.speedIncI = speed_inc; if_c.speedDecI = speed_dec;
                if_c.powerIncI = power_inc; if_c.powerDecI = power_dec;
            end
        endcase
    endtask

    task automatic wait_step(input int d, input int budget, input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step_stb[d] && n < budget);
        checkOutput({tag, "_seen"}, 32'(step_stb[d]), 1);
    endtask

    task automatic wait_round(input int d, input int budget, input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!round_stb[d] && n < budget);
        checkOutput({tag, "_seen"}, 32'(round_stb[d]), 1);
    endtask

    function automatic int ramp_inc(input int p);
        int r;
        r = p - (p >> 4);
        return (r < 40) ? 40 : r;
    endfunction

    initial begin
        int n;
        int sum;
        int saw;
        int p_model;
        int pw_model;
        int exp_b2 [15] = '{400, 400, 400, 375, 375, 375, 375, 375, 375, 375, 398, 398, 398, 398, 400};

        n_rst = 1'b0;
        for (int d = 0; d < 3; d++) applyStimulus(d, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("rst_step", 32'(step[0]), 0);
        checkOutput("rst_step_stb", 32'(step_stb[0]), 0);
        checkOutput("rst_round_stb", 32'(round_stb[0]), 0);
        checkOutput("rst_period", 32'(period[0]), 400);
        checkOutput("rst_power", 32'(power[0]), 100);
        checkOutput("rst_run", 32'(run[0]), 0);
        checkOutput("rst_halt", 32'(halt[0]), 0);
        n_rst = 1'b1;
        @(negedge clk);

        // Instance A: ARM lasts one cycle, steps are 400 clocks, rounds are 4800 clocks.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("a_arm_run", 32'(run[0]), 0);
        @(negedge clk);
        checkOutput("a_run", 32'(run[0]), 1);
        sum = 0;
        for (int k = 1; k <= 24; k++) begin
            wait_step(0, 1000, "a_step", n);
            checkOutput("a_step_len", n, 400);
            checkOutput("a_step_idx", 32'(step[0]), k % 12);
            checkOutput("a_round_stb", 32'(round_stb[0]), (k % 12 == 0) ? 1 : 0);
            if (k > 12) sum += n;
        end
        checkOutput("a_round_len", sum, 4800);

        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
        wait_step(0, 1000, "a_rev1", n);
        checkOutput("a_rev1_idx", 32'(step[0]), 11);
        checkOutput("a_rev1_round", 32'(round_stb[0]), 1);
        wait_step(0, 1000, "a_rev2", n);
        checkOutput("a_rev2_idx", 32'(step[0]), 10);
        checkOutput("a_rev2_round", 32'(round_stb[0]), 0);

        repeat (100) @(negedge clk);
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("a_halt", 32'(halt[0]), 1);
        checkOutput("a_halt_run", 32'(run[0]), 0);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
        saw = 0;
        repeat (600) begin
            @(negedge clk);
            if (step_stb[0] || round_stb[0]) saw++;
        end
        checkOutput("a_halt_nostb", saw, 0);
        checkOutput("a_halt_held", 32'(halt[0]), 1);
        checkOutput("a_halt_step", 32'(step[0]), 10);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("a_idle_halt", 32'(halt[0]), 0);
        checkOutput("a_idle_step", 32'(step[0]), 0);
        checkOutput("a_idle_period", 32'(period[0]), 400);
        checkOutput("a_idle_power", 32'(power[0]), 100);

        // Instance B: held speedIncI ramps after every fourth qualifying round.
        applyStimulus(1, 1, 0, 0, 1, 0, 0, 0);
        for (int r = 1; r <= 8; r++) begin
            wait_round(1, 2000, "b_inc", n);
            checkOutput("b_inc_period", 32'(period[1]), (r < 4) ? 400 : (r < 8) ? 375 : 352);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("b_idle_period", 32'(period[1]), 400);
        checkOutput("b_idle_power", 32'(power[1]), 100);
        checkOutput("b_idle_run", 32'(run[1]), 0);

        applyStimulus(1, 1, 0, 0, 1, 0, 0, 0);
        for (int r = 1; r <= 15; r++) begin
            wait_round(1, 2000, "b_mix", n);
            checkOutput("b_mix_period", 32'(period[1]), exp_b2[r-1]);
            if (r == 6) applyStimulus(1, 1, 0, 0, 0, 1, 0, 0);
        end

        // Instance C: no hold, so the period ramps every round down to the floor.
        applyStimulus(2, 1, 0, 0, 1, 0, 1, 0);
        p_model  = 400;
        pw_model = 105;
        for (int r = 1; r <= 100; r++) begin
            wait_round(2, 2000, "c_up", n);
            p_model = ramp_inc(p_model);
`ifdef M3_POWER_RAMP_EN
            pw_model = (pw_model + 10 >= 1000) ? 1000 : pw_model + 10;
`endif
            checkOutput("c_up_period", 32'(period[2]), p_model);
            checkOutput("c_up_power", 32'(power[2]), pw_model);
        end
        checkOutput("c_period_floor", 32'(period[2]), 40);

        applyStimulus(2, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("c_idle_period", 32'(period[2]), 400);
        checkOutput("c_idle_power", 32'(power[2]), 105);
        applyStimulus(2, 1, 0, 0, 1, 0, 0, 1);
        p_model  = 400;
        pw_model = 105;
        for (int r = 1; r <= 12; r++) begin
            wait_round(2, 2000, "c_dn", n);
            p_model = ramp_inc(p_model);
`ifdef M3_POWER_RAMP_EN
            pw_model = (pw_model < 10) ? 0 : pw_model - 10;
`endif
            checkOutput("c_dn_period", 32'(period[2]), p_model);
            checkOutput("c_dn_power", 32'(power[2]), pw_model);
        end

        // Asynchronous reset in the middle of a step.
        repeat (17) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("arst_step", 32'(step[2]), 0);
        checkOutput("arst_step_stb", 32'(step_stb[2]), 0);
        checkOutput("arst_round_stb", 32'(round_stb[2]), 0);
        checkOutput("arst_period", 32'(period[2]), 400);
        checkOutput("arst_power", 32'(power[2]), 105);
        checkOutput("arst_run", 32'(run[2]), 0);
        checkOutput("arst_halt", 32'(halt[2]), 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/m3_ramp_sequencer.md
M3_RAMP_SEQUENCER -- requirements
Module: m3_ramp_sequencer

Interface
REQ-001 SHALL have parameter PERIOD_W, default 22, period/counter width in bits.
REQ-002 SHALL have parameter PERIOD_MAX, default 4000000, slowest step period in clocks.
REQ-003 SHALL have parameter PERIOD_MIN, default 40, fastest step period in clocks.
REQ-004 SHALL have parameter STEPS, default 12, steps per electrical round (2..16).
REQ-005 SHALL have parameter RAMP_SHIFT, default 4; period changes by period>>RAMP_SHIFT per ramp event.
REQ-006 SHALL have parameter HOLD_ROUNDS, default 3, extra qualifying rounds required before each ramp event.
REQ-007 SHALL have parameters POWER_W=10, POWER_MIN=0, POWER_MAX=1000, POWER_INIT=100, POWER_STEP=10.
REQ-008 SHALL have ports: clkI in 1 clock; nRstI in 1 reset, asynchronous, active-low.
REQ-009 SHALL have ports: startI in 1 run enable; forceStopI in 1 emergency stop; invRotateI in 1 reverse step order.
REQ-010 SHALL have ports: speedIncI in 1 shorten period; speedDecI in 1 lengthen period; powerIncI in 1; powerDecI in 1.
REQ-011 SHALL have ports: stepO out 4 current step; stepStbO out 1 step-boundary pulse; roundStbO out 1 round-wrap pulse.
REQ-012 SHALL have ports: periodO out PERIOD_W active period; powerO out POWER_W power level; runO out 1 running; haltO out 1 force-stopped.

Function
REQ-013 SHALL implement FSM IDLE->ARM->RUN; IDLE->ARM when startI=1; ARM->RUN unconditionally after one cycle.
REQ-014 SHALL go RUN/ARM->HALT on forceStopI=1; HALT->IDLE only when startI=0; startI=0 in any state -> IDLE next cycle.
REQ-015 SHALL, in ARM, load remain=periodO and stepO=0; runO=1 only in RUN; haltO=1 only in HALT.
REQ-016 SHALL, in RUN, decrement remain each cycle; at remain==1 pulse stepStbO one cycle and reload remain=periodO (step length = periodO clocks).
REQ-017 SHALL on stepStbO advance stepO: forward 0..STEPS-1 wrap to 0; invRotateI=1 counts down, 0 wraps to STEPS-1; invRotateI sampled at the stepStbO cycle.
REQ-018 SHALL pulse roundStbO coincident with stepStbO on wrap (either direction).
REQ-019 SHALL evaluate speed ramp only on roundStbO: request INC if speedIncI&!speedDecI, DEC if speedDecI&!speedIncI, else none.
REQ-020 SHALL hold a round counter: none -> reload HOLD_ROUNDS; request differing from last direction -> reload HOLD_ROUNDS, record direction; same direction & counter>0 -> decrement; counter==0 -> apply ramp, reload HOLD_ROUNDS.
REQ-021 SHALL compute ramp in PERIOD_W+1 bits, INC: period-(period>>RAMP_SHIFT), DEC: period+(period>>RAMP_SHIFT), then clamp result to [PERIOD_MIN,PERIOD_MAX].
REQ-022 SHALL make a new periodO take effect at the next remain reload, never truncating the current step.
REQ-023 SHALL in HALT freeze stepO, remain, periodO and powerO; stepStbO/roundStbO held 0.
REQ-024 SHALL on entry to IDLE set periodO=PERIOD_MAX, powerO=POWER_INIT, stepO=0, round counter=HOLD_ROUNDS.

Reset
REQ-025 SHALL on nRstI=0 asynchronously set state IDLE, stepO=0, stepStbO=0, roundStbO=0, periodO=PERIOD_MAX, powerO=POWER_INIT, runO=0, haltO=0, remain=PERIOD_MAX, last direction=INC.

Configuration
REQ-026 SHALL, with M3_POWER_RAMP_EN defined, on roundStbO add POWER_STEP (powerIncI&!powerDecI) or subtract (powerDecI&!powerIncI), saturating at POWER_MAX/POWER_MIN, both/neither hold.
REQ-027 SHALL, without M3_POWER_RAMP_EN, tie powerO to POWER_INIT and ignore powerIncI/powerDecI.

Structure
REQ-028 SHALL place FSM state enum, direction encoding and default parameter constants in shared package m3_pkg.
REQ-029 SHALL implement clamped ramp arithmetic in sub-module m3_period_ramp (period in, direction in, clamped period out), combinational.

Verification
REQ-030 SHALL cover: PERIOD_MAX=400, startI=1 -> ARM 1 cycle, first stepStbO 400 cycles into RUN, roundStbO every 4800 cycles, stepO 0..11.
REQ-031 SHALL cover: speedIncI=1 held -> periodO 400->375 after 4th round, ->352 after 8th; continued -> settles at 40, never below.
REQ-032 SHALL cover: speedIncI 2 rounds then speedDecI -> counter reloads, no change until 4 DEC rounds, then 375->398 clamped to 400 path verified.
REQ-033 SHALL cover: invRotateI=1 at stepO=0 stepStb -> stepO=11, roundStbO pulses; next stepO=10.
REQ-034 SHALL cover: forceStopI mid-step -> haltO=1, counters frozen, startI still 1 keeps HALT; startI=0 -> IDLE, periodO=400, powerO=100.
REQ-035 SHALL cover: M3_POWER_RAMP_EN, powerIncI=1 from 995-range -> saturates 1000; powerDecI from 5 -> 0; nRstI pulse mid-run -> all REQ-025 values.
